// File: rtl/tdm_slot_scheduler.sv
// TDM frame/slot sequencer: recovers frame position from f0/c4 in the clk50 domain and issues bit strobes,
// slot/bit indices, per-slot routing enables and a frame-count interrupt. TDM_FRAME_CHECK_EN adds frame_err.
module tdm_slot_scheduler #(
  parameter int unsigned SLOTS          = 48,
  parameter int unsigned BITS_PER_SLOT  = 8,
  parameter int unsigned C4_PER_BIT     = 2,
  parameter int unsigned FRAMES_PER_INT = 8
) (
  input  logic       clk50,
  input  logic       reset_n,
  input  logic       c4,
  input  logic       f0,
  input  logic       mask_we,
  input  logic [5:0] mask_addr,
  input  logic       mask_wdata,
  input  logic       int_ack,
  output logic       bit_strobe,
  output logic [5:0] slot_num,
  output logic [2:0] bit_num,
  output logic       slot_active,
  output logic       frame_start,
  output logic       locked,
`ifdef TDM_FRAME_CHECK_EN
  output logic       frame_err,
`endif
  output logic       cpu_int
);

  localparam int unsigned POS_W        = 10;
  localparam int unsigned POS_MAX      = SLOTS * BITS_PER_SLOT * C4_PER_BIT - 1;
  localparam int unsigned POS_PER_SLOT = C4_PER_BIT * BITS_PER_SLOT;

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;

  logic [2:0]       c4_sync_q;
  logic [1:0]       f0_sync_q;
  logic             c4_rise_q, f0_smp_q;
  logic             f0_prev_q, f0_prev_d;
  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_inc;
  logic             strobe_q, strobe_d, fs_q, fs_d, act_q, act_d;
  logic             locked_q, locked_d, int_q, int_d;
  logic [5:0]       slot_q, slot_d;
  logic [2:0]       bit_q, bit_d;
  logic [SLOTS-1:0] mask_q, mask_d;
  logic [7:0]       cnt_q, cnt_d;
`ifdef TDM_FRAME_CHECK_EN
  logic             err_q, err_d;
  assign frame_err = err_q;
`endif

  assign pos_inc     = pos_q + POS_W'(1);
  assign bit_strobe  = strobe_q;
  assign slot_num    = slot_q;
  assign bit_num     = bit_q;
  assign slot_active = act_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign cpu_int     = int_q;

  // Two-flop synchronisers; the registered rise pulse and its f0 sample stay aligned.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      c4_sync_q <= '0;
      f0_sync_q <= '1;
      c4_rise_q <= 1'b0;
      f0_smp_q  <= 1'b1;
    end else begin
      c4_sync_q <= {c4_sync_q[1:0], c4};
      f0_sync_q <= {f0_sync_q[0], f0};
      c4_rise_q <= c4_sync_q[1] & ~c4_sync_q[2];
      f0_smp_q  <= f0_sync_q[1];
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    f0_prev_d = f0_prev_q;
    strobe_d  = 1'b0;
    fs_d      = 1'b0;
    slot_d    = slot_q;
    bit_d     = bit_q;
    act_d     = act_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    int_d     = int_q & ~int_ack;
`ifdef TDM_FRAME_CHECK_EN
    err_d     = err_q & ~int_ack;
`endif

    if (mask_we && (32'(mask_addr) < SLOTS)) mask_d[mask_addr] = mask_wdata;

    if (c4_rise_q) begin
      f0_prev_d = f0_smp_q;
      if (state_q == HUNT) begin
        pos_d = '0;
        if (!f0_smp_q) begin
          state_d = RUN;
          fs_d    = 1'b1;
        end
      end else if (!f0_smp_q) begin
        // Realign; a held-low f0 only produces the first frame_start.
`ifdef TDM_FRAME_CHECK_EN
        if ((32'(pos_q) != POS_MAX) && (pos_q != '0)) err_d = 1'b1;
`endif
        pos_d = '0;
        fs_d  = f0_prev_q;
      end else if (32'(pos_q) == POS_MAX) begin
        pos_d = '0;
`ifdef TDM_FRAME_CHECK_EN
        err_d   = 1'b1;
        state_d = HUNT;
`endif
      end else begin
        pos_d = pos_inc;
        if ((32'(pos_inc) % C4_PER_BIT) == (C4_PER_BIT - 1)) begin
          strobe_d = 1'b1;
          bit_d    = 3'((32'(pos_inc) / C4_PER_BIT) % BITS_PER_SLOT);
          slot_d   = 6'(32'(pos_inc) / POS_PER_SLOT);
          act_d    = mask_q[slot_d];
        end
      end
    end

    locked_d = (state_d == RUN);

    // Frame counter runs off the registered frame_start so cpu_int follows it by one cycle.
    if (fs_q) begin
      if ((32'(cnt_q) + 32'd1) == FRAMES_PER_INT) begin
        int_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      pos_q     <= '0;
      f0_prev_q <= 1'b1;
      strobe_q  <= 1'b0;
      fs_q      <= 1'b0;
      slot_q    <= '0;
      bit_q     <= '0;
      act_q     <= 1'b1;
      mask_q    <= '1;
      cnt_q     <= '0;
      int_q     <= 1'b0;
      locked_q  <= 1'b0;
`ifdef TDM_FRAME_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      f0_prev_q <= f0_prev_d;
      strobe_q  <= strobe_d;
      fs_q      <= fs_d;
      slot_q    <= slot_d;
      bit_q     <= bit_d;
      act_q     <= act_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      int_q     <= int_d;
      locked_q  <= locked_d;
`ifdef TDM_FRAME_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Bench for tdm_slot_scheduler: table vectors, frame/mask/interrupt sequences and randomized f0/mask/ack
// traffic checked against a frame-position reference model. Honours TDM_FRAME_CHECK_EN.
`timescale 1ns/1ps
module tb_tdm_slot_scheduler;

  localparam int NSLOT = 48;
  localparam int NBPS  = 8;
  localparam int NC4   = 2;
  localparam int NFPI  = 8;
  localparam int PMAX  = NSLOT * NBPS * NC4 - 1;

  logic       clk50 = 1'b0;
  logic       reset_n, c4, f0, mask_we, mask_wdata, int_ack;
  logic [5:0] mask_addr;
  logic       bit_strobe, slot_active, frame_start, locked, cpu_int;
  logic [5:0] slot_num;
  logic [2:0] bit_num;
`ifdef TDM_FRAME_CHECK_EN
  logic       frame_err;
`endif

  tdm_slot_scheduler #(
    .SLOTS(NSLOT), .BITS_PER_SLOT(NBPS), .C4_PER_BIT(NC4), .FRAMES_PER_INT(NFPI)
  ) dut (
    .clk50(clk50), .reset_n(reset_n), .c4(c4), .f0(f0),
    .mask_we(mask_we), .mask_addr(mask_addr), .mask_wdata(mask_wdata), .int_ack(int_ack),
    .bit_strobe(bit_strobe), .slot_num(slot_num), .bit_num(bit_num), .slot_active(slot_active),
    .frame_start(frame_start), .locked(locked),
`ifdef TDM_FRAME_CHECK_EN
    .frame_err(frame_err),
`endif
    .cpu_int(cpu_int)
  );

  always #10 clk50 = ~clk50;

  int vectors = 0;
  int errors  = 0;
  int mon_strobes = 0;
  int mon_fs = 0;
  int inact = 0;

  always @(negedge clk50) begin
    if (bit_strobe === 1'b1) mon_strobes <= mon_strobes + 1;
    if (frame_start === 1'b1) mon_fs <= mon_fs + 1;
  end

  // Reference model: frame position in c4 ticks, derived outputs by plain arithmetic.
  bit m_lock, m_prev, m_int, m_pend, m_act, m_err;
  int m_pos, m_cnt, m_slot, m_bit;
  bit m_mask [NSLOT];

  typedef struct {
    bit         f0v;
    bit         strobe;
    bit         fs;
    logic [5:0] slot;
    logic [2:0] bitn;
    bit         lock;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Effect of one clk50 edge on the interrupt/error levels.
  task automatic apply_clock(input bit ack);
    m_int  = m_pend | (m_int & ~ack);
    m_pend = 1'b0;
    if (ack) m_err = 1'b0;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0; c4 = 1'b0; f0 = 1'b1; mask_we = 1'b0; int_ack = 1'b0;
    mask_addr = '0; mask_wdata = 1'b0;
    @(negedge clk50); @(negedge clk50);
    reset_n = 1'b1;
    m_lock = 0; m_prev = 1; m_int = 0; m_pend = 0; m_act = 1; m_err = 0;
    m_pos = 0; m_cnt = 0; m_slot = 0; m_bit = 0;
    foreach (m_mask[i]) m_mask[i] = 1'b1;
    @(negedge clk50);
    chk("reset_outputs", 32'({bit_strobe, frame_start, slot_num, bit_num, slot_active, locked, cpu_int}),
        32'({1'b0, 1'b0, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0}));
`ifdef TDM_FRAME_CHECK_EN
    chk("reset_frame_err", 32'(frame_err), 32'd0);
`endif
  endtask

  // One c4 period (4 clk50): rise with f0, outputs must appear exactly 4 clocks after the pin edge.
  task automatic c4_cycle(input bit f0v);
    bit exp_strobe, exp_fs;
    apply_clock(1'b0);
    f0 = f0v; c4 = 1'b1;
    @(negedge clk50); @(negedge clk50);
    c4 = 1'b0;
    @(negedge clk50);
    chk("strobe_before_latency", 32'(bit_strobe), 32'd0);
    @(negedge clk50);
    exp_strobe = 0; exp_fs = 0;
    if (!m_lock) begin
      m_pos = 0;
      if (!f0v) begin m_lock = 1; exp_fs = 1; end
    end else if (!f0v) begin
`ifdef TDM_FRAME_CHECK_EN
      if (m_pos != PMAX && m_pos != 0) m_err = 1;
`endif
      m_pos = 0;
      exp_fs = m_prev;
    end else if (m_pos == PMAX) begin
      m_pos = 0;
`ifdef TDM_FRAME_CHECK_EN
      m_err = 1; m_lock = 0;
`endif
    end else begin
      m_pos++;
      if (m_pos % NC4 == NC4 - 1) begin
        exp_strobe = 1;
        m_bit  = (m_pos / NC4) % NBPS;
        m_slot = m_pos / (NC4 * NBPS);
        m_act  = m_mask[m_slot];
      end
    end
    m_prev = f0v;
    if (exp_fs) begin
      if (m_cnt + 1 == NFPI) begin m_pend = 1; m_cnt = 0; end
      else m_cnt++;
    end
    chk("c4_outputs", 32'({bit_strobe, frame_start, slot_num, bit_num, slot_active, locked, cpu_int}),
        32'({exp_strobe, exp_fs, 6'(m_slot), 3'(m_bit), m_act, m_lock, m_int}));
`ifdef TDM_FRAME_CHECK_EN
    chk("c4_frame_err", 32'(frame_err), 32'(m_err));
`endif
    if (bit_strobe === 1'b1 && slot_active === 1'b0) inact++;
  endtask

  task automatic mask_write(input logic [5:0] a, input bit d);
    mask_we = 1'b1; mask_addr = a; mask_wdata = d;
    @(negedge clk50);
    mask_we = 1'b0;
    apply_clock(1'b0);
    if (int'(a) < NSLOT) m_mask[a] = d;
  endtask

  task automatic ack_pulse(input bit a, input string name);
    int_ack = a;
    @(negedge clk50);
    int_ack = 1'b0;
    apply_clock(a);
    chk(name, 32'(cpu_int), 32'(m_int));
`ifdef TDM_FRAME_CHECK_EN
    chk({name, "_err"}, 32'(frame_err), 32'(m_err));
`endif
  endtask

  task automatic run_frame();
    c4_cycle(1'b0);
    repeat (PMAX) c4_cycle(1'b1);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_str, s_fs;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 6'd0, 3'd0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 6'd0, 3'd1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 6'd0, 3'd1, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 6'd0, 3'd2, 1'b1};

    reset_dut();

    // No frame pulse: stays hunting, no strobes.
    #1 s_str = mon_strobes;
    repeat (PMAX + 1) c4_cycle(1'b1);
    #1;
    chk("hunt_strobes", 32'(mon_strobes - s_str), 32'd0);
    chk("hunt_locked", 32'(locked), 32'd0);
    chk("hunt_slot_active", 32'(slot_active), 32'd1);

    // Lock, held-low f0 and first strobes.
    for (int i = 0; i < 9; i++) begin
      c4_cycle(tbl[i].f0v);
      chk($sformatf("tbl_vec%0d", i), 32'({bit_strobe, frame_start, slot_num, bit_num, locked}),
          32'({tbl[i].strobe, tbl[i].fs, tbl[i].slot, tbl[i].bitn, tbl[i].lock}));
    end
    while (m_pos != PMAX) c4_cycle(1'b1);

    // One full aligned frame.
    #1 s_str = mon_strobes; s_fs = mon_fs;
    run_frame();
    #1;
    chk("frame_strobes", 32'(mon_strobes - s_str), 32'd384);
    chk("frame_fs_count", 32'(mon_fs - s_fs), 32'd1);
    chk("frame_last_idx", 32'({slot_num, bit_num}), 32'({6'd47, 3'd7}));

    // Slot mask: slot 5 disabled, out-of-range address ignored.
    mask_write(6'd5, 1'b0);
    mask_write(6'd50, 1'b0);
    inact = 0;
    run_frame();
    chk("slot5_inactive_strobes", 32'(inact), 32'd8);
    mask_write(6'd5, 1'b1);

    // Interrupt after 8 frame_starts; reset also restores the mask.
    mask_write(6'd7, 1'b0);
    reset_dut();
    repeat (7) run_frame();
    chk("int_before_8th", 32'(cpu_int), 32'd0);
    c4_cycle(1'b0);
    ack_pulse(1'b1, "int_set_wins");
    ack_pulse(1'b1, "int_ack_clear");
    repeat (PMAX) c4_cycle(1'b1);
    run_frame();
    chk("int_after_9th", 32'(cpu_int), 32'd0);

    // Randomized f0 jitter, mask writes and acks.
    for (int k = 0; k < 2500; k++) begin
      bit fv;
      fv = 1'b1;
      if (!m_lock || m_pos == PMAX || (!m_prev && m_pos == 0 && $urandom_range(0, 1) == 0)) fv = 1'b0;
      else if ($urandom_range(0, 599) == 0) fv = 1'b0;
      c4_cycle(fv);
      if ($urandom_range(0, 39) == 0) mask_write(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 149) == 0) ack_pulse(1'b1, "rand_ack");
    end

    // Missing frame pulse.
    run_frame();
    c4_cycle(1'b1);
`ifdef TDM_FRAME_CHECK_EN
    chk("missing_f0_err", 32'(frame_err), 32'd1);
    chk("missing_f0_unlock", 32'(locked), 32'd0);
    repeat (PMAX) c4_cycle(1'b1);
    run_frame();
    chk("relock", 32'(locked), 32'd1);
    ack_pulse(1'b1, "err_ack");
    chk("err_cleared", 32'(frame_err), 32'd0);
`else
    chk("freerun_locked", 32'(locked), 32'd1);
    repeat (PMAX) c4_cycle(1'b1);
    chk("freerun_last_idx", 32'({locked, slot_num, bit_num}), 32'({1'b1, 6'd47, 3'd7}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tdm_slot_scheduler.md
# tdm_slot_scheduler

Frame/slot sequencer for the TDM converter path. Recovers frame position from the ST-bus style `f0`/`c4` timing in the `clk50` domain. Issues one bit strobe per TDM bit together with the current slot/bit index and a per-slot routing enable, which tell the 384-bit STM/DT shift path when to shift. Raises a CPU interrupt every N frames, cleared by an acknowledge handshake.

## Interface
Parameters:
- `SLOTS`, 48: timeslots per frame (48 × 8 = 384 bits).
- `BITS_PER_SLOT`, 8: bits per timeslot.
- `C4_PER_BIT`, 2: `c4` rising edges per TDM bit.
- `FRAMES_PER_INT`, 8: frames between `cpu_int` assertions, range 1..255.

Ports:
- `clk50`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `c4`  in  1  TDM bit clock, asynchronous to `clk50`.
- `f0`  in  1  frame pulse, active low, asynchronous.
- `mask_we`  in  1  slot-mask write strobe.
- `mask_addr`  in  6  slot index for the write.
- `mask_wdata`  in  1  enable value to write.
- `int_ack`  in  1  CPU acknowledge; single-cycle pulse or level.
- `bit_strobe`  out  1  one-cycle pulse per TDM bit.
- `slot_num`  out  6  current slot, 0..SLOTS-1.
- `bit_num`  out  3  current bit within slot, 0..BITS_PER_SLOT-1.
- `slot_active`  out  1  mask bit of `slot_num`.
- `frame_start`  out  1  one-cycle pulse at frame alignment.
- `locked`  out  1  high in RUN state.
- `cpu_int`  out  1  interrupt level.

## Operation
- **Synchroniser:** `c4` and `f0` each pass through a 2-flop synchroniser. `c4_rise` is the synchronised rise, detected by a third flop. `f0` is sampled only on `c4_rise`.
- **Position counter:** `pos`, 10 bits, range 0..SLOTS·BITS_PER_SLOT·C4_PER_BIT−1 (767).
- **State HUNT** (after reset): `pos` is held at 0. `bit_strobe` and `frame_start` stay low. On a `c4_rise` with sampled `f0`=0, `pos` is set to 0, `frame_start` pulses, and the state moves to RUN.
- **State RUN**, on each `c4_rise`:
  - If `f0`=0: `pos` is set to 0. `frame_start` pulses only when the previous `c4_rise` sample of `f0` was 1, so a multi-cycle `f0` low gives one pulse.
  - Otherwise `pos` increments. At 767 it wraps to 0 (free-run).
- **Bit strobe:** `bit_strobe` pulses on the `c4_rise` where `pos mod C4_PER_BIT == C4_PER_BIT−1`. On that strobe, `bit_num` = (pos / C4_PER_BIT) mod BITS_PER_SLOT and `slot_num` = pos / (C4_PER_BIT·BITS_PER_SLOT).
- **Slot mask:** 48 bits, all 1 on reset.
  - With `mask_we`=1 and `mask_addr` < SLOTS, `mask[mask_addr]` is set to `mask_wdata` on the next edge.
  - Addresses ≥ SLOTS are ignored.
  - `slot_active` is registered from `mask[slot_num_next]`, so it is always consistent with `slot_num`.
  - A write to the current slot is visible at the next slot update, not mid-bit.
- **Interrupt:**
  - 8-bit `frame_cnt` increments on each `frame_start` in RUN.
  - When the incremented value equals FRAMES_PER_INT, `cpu_int` is set and `frame_cnt` is set to 0.
  - `int_ack`=1 clears `cpu_int`.
  - If set and ack occur in the same cycle, set wins.
  - A further set while `cpu_int`=1 is not queued.
- **Reset values:** all outputs 0 except `slot_num`=0, `bit_num`=0, `slot_active`=1. `pos`=0, `frame_cnt`=0, state HUNT.
- **Reset mid-frame:** immediate return to HUNT. The mask is reinitialised to all 1.

## Timing
- `c4` pin edge to `c4_rise` pulse: 3 `clk50` cycles.
- `c4_rise` to `bit_strobe`/`slot_num`/`bit_num`/`slot_active`/`frame_start`: 1 cycle (registered). Total pin-to-output latency: 4 `clk50` cycles.
- `frame_start` to `cpu_int` rising: 1 cycle.
- `int_ack` to `cpu_int` low: 1 cycle.
- `mask_we` to mask update: 1 cycle.
- Minimum `c4` high or low time: 2 `clk50` periods (4.096 MHz against 50 MHz satisfies this).

## Configuration
- `TDM_FRAME_CHECK_EN` defined:
  - Adds output `frame_err` (1 bit, reset 0).
  - In RUN, a `c4_rise` with `pos`=767 and `f0`=1 (missing frame pulse) sets `frame_err`, returns the state to HUNT and clears `locked`.
  - An `f0`=0 sample with `pos` ≠ 767 and ≠ 0 (early frame pulse) sets `frame_err` but still realigns.
  - `frame_err` is sticky and is cleared by `int_ack`.
- `TDM_FRAME_CHECK_EN` undefined:
  - No `frame_err` port.
  - `pos` free-runs through wrap and `locked` stays high once set.

## Test plan
- Reset, then 768 `c4` cycles with `f0` held high: `locked`=0, no `bit_strobe`, `slot_active`=1.
- `f0` low for one `c4` cycle, then one full frame: one `frame_start`; 384 `bit_strobe` pulses; `slot_num`/`bit_num` step 0/0 to 47/7; each output 4 `clk50` cycles after its `c4` edge.
- Write `mask[5]`=0 via `mask_we`, `mask_addr`=5: `slot_active`=0 exactly during the 8 strobes of slot 5; `mask_addr`=50 leaves the mask unchanged.
- Nine aligned frames with FRAMES_PER_INT=8: `cpu_int` rises 1 cycle after the 8th `frame_start`; `int_ack` clears it next cycle; an ack coincident with a set leaves `cpu_int`=1.
- `f0` held low for 3 `c4` cycles: single `frame_start`, `pos` held at 0.
- With `TDM_FRAME_CHECK_EN`, omit `f0` for one frame: `frame_err`=1 and `locked`=0 at the `c4_rise` after `pos`=767; next `f0` relocks; `int_ack` clears `frame_err`.
